// File: rtl/ch_adv_collector.sv
// Cluster-head advertisement collector: builds a 16-entry table and streams it to the KCH selector.
// Optional duplicate-ID merge is compiled in when the CH_DEDUP_EN macro is defined.
module ch_adv_collector #(
    parameter int ENTRIES = 16,
    parameter int W       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      adv_valid,
    output logic                      adv_ready,
    input  logic [W-1:0]              adv_id,
    input  logic [W-1:0]              adv_qvalue,
    input  logic [W-1:0]              adv_hops,
    input  logic                      flush,
    input  logic                      clear,
    output logic [W-1:0]              CH_ID,
    output logic [W-1:0]              CH_QValue,
    output logic [W-1:0]              CH_Hops,
    output logic                      en_KCH,
    output logic                      emit_done,
    output logic [$clog2(ENTRIES):0]  count,
    output logic                      overflow
);

    localparam int AW = $clog2(ENTRIES);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EMIT    = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  idx;
    logic [W-1:0]   id_tab   [ENTRIES];
    logic [W-1:0]   q_tab    [ENTRIES];
    logic [W-1:0]   hops_tab [ENTRIES];

    logic           accept;
    logic           clear_act;
    logic           hit;
    logic [AW-1:0]  hit_idx;

    assign adv_ready = (state == COLLECT);
    assign accept    = adv_valid & adv_ready & (adv_id != {W{1'b0}});
    assign clear_act = clear & ((state == COLLECT) | (state == EMIT));

`ifdef CH_DEDUP_EN
    // Parallel ID compare over the valid entries; IDs are unique so the OR of matches is the index
    always_comb begin
        hit     = 1'b0;
        hit_idx = {AW{1'b0}};
        for (int i = 0; i < ENTRIES; i++) begin
            hit     = hit | ((CW'(i) < count) & (id_tab[i] == adv_id));
            hit_idx = hit_idx | (((CW'(i) < count) & (id_tab[i] == adv_id)) ? AW'(i) : {AW{1'b0}});
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_idx = {AW{1'b0}};
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; clear beats flush and aborts an emission in progress
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: begin
                if (clear) begin
                    state_next = COLLECT;
                end else if (flush) begin
                    state_next = EMIT;
                end else begin
                    state_next = COLLECT;
                end
            end
            EMIT: begin
                if (clear) begin
                    state_next = COLLECT;
                end else if (idx >= count) begin
                    state_next = DONE;
                end else begin
                    state_next = EMIT;
                end
            end
            DONE: begin
                state_next = COLLECT;
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    // Table bookkeeping: clear, merge, append, overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                id_tab[i]   <= {W{1'b0}};
                q_tab[i]    <= {W{1'b0}};
                hops_tab[i] <= {W{1'b0}};
            end
            count    <= {CW{1'b0}};
            overflow <= 1'b0;
        end else if (clear_act) begin
            for (int i = 0; i < ENTRIES; i++) begin
                id_tab[i]   <= {W{1'b0}};
                q_tab[i]    <= {W{1'b0}};
                hops_tab[i] <= {W{1'b0}};
            end
            count    <= {CW{1'b0}};
            overflow <= 1'b0;
        end else if (accept) begin
            if (hit) begin
                if (adv_hops < hops_tab[hit_idx]) begin
                    hops_tab[hit_idx] <= adv_hops;
                    q_tab[hit_idx]    <= adv_qvalue;
                end else if (adv_hops == hops_tab[hit_idx]) begin
                    q_tab[hit_idx]    <= adv_qvalue;
                end else begin
                    q_tab[hit_idx]    <= q_tab[hit_idx];
                end
            end else if (count < CW'(ENTRIES)) begin
                id_tab[count[AW-1:0]]   <= adv_id;
                q_tab[count[AW-1:0]]    <= adv_qvalue;
                hops_tab[count[AW-1:0]] <= adv_hops;
                count                   <= count + CW'(1);
            end else begin
                overflow <= 1'b1;
            end
        end else begin
            overflow <= overflow;
        end
    end

    // Emission datapath; payload outputs hold their value while en_KCH is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= {CW{1'b0}};
            CH_ID     <= {W{1'b0}};
            CH_QValue <= {W{1'b0}};
            CH_Hops   <= {W{1'b0}};
            en_KCH    <= 1'b0;
            emit_done <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    idx       <= {CW{1'b0}};
                    en_KCH    <= 1'b0;
                    emit_done <= 1'b0;
                end
                EMIT: begin
                    if (clear) begin
                        en_KCH    <= 1'b0;
                        emit_done <= 1'b0;
                    end else if (idx < count) begin
                        CH_ID     <= id_tab[idx[AW-1:0]];
                        CH_QValue <= q_tab[idx[AW-1:0]];
                        CH_Hops   <= hops_tab[idx[AW-1:0]];
                        en_KCH    <= 1'b1;
                        emit_done <= 1'b0;
                        idx       <= idx + CW'(1);
                    end else begin
                        en_KCH    <= 1'b0;
                        emit_done <= 1'b1;
                    end
                end
                DONE: begin
                    en_KCH    <= 1'b0;
                    emit_done <= 1'b0;
                end
                default: begin
                    en_KCH    <= 1'b0;
                    emit_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ch_adv_collector.md
# ch_adv_collector

Collects cluster-head (CH) advertisements received by a sensor node into a 16-entry table and streams the table, one entry per cycle, into the downstream known-cluster-head selector. The selector picks the minimum-hop, maximum-Q-value CH. This block sits directly upstream of it. It drives the selector's `CH_ID`/`CH_QValue`/`CH_Hops`/`en_KCH` inputs and owns table bookkeeping: insertion, duplicate merge, overflow and clear.

## Interface
- `ENTRIES`, 16, table depth; count width is clog2(ENTRIES)+1.
- `W`, 16, width of ID, Q-value and hop fields.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `adv_valid` in 1: advertisement present.
- `adv_ready` out 1: block can accept an advertisement.
- `adv_id` in W: CH ID; 0 is invalid.
- `adv_qvalue` in W: unsigned Q-value (U1.15).
- `adv_hops` in W: unsigned hop count.
- `flush` in 1: start emission of the table.
- `clear` in 1: empty the table.
- `CH_ID` out W: emitted entry ID.
- `CH_QValue` out W: emitted entry Q-value.
- `CH_Hops` out W: emitted entry hops.
- `en_KCH` out 1: emitted entry valid.
- `emit_done` out 1: one-cycle pulse at end of emission.
- `count` out 5: number of valid entries.
- `overflow` out 1: sticky flag; a new ID was dropped because the table was full.

## Operation
- States:
  - COLLECT is the reset state.
  - EMIT streams the table.
  - DONE lasts one cycle and then returns to COLLECT.
- `adv_ready` is 1 in COLLECT and 0 otherwise. It is decoded directly from the state register.
- Accepting an advertisement (`adv_valid & adv_ready`) in COLLECT:
  - `adv_id == 0`: consumed and discarded; no state change.
  - ID already in the table: the entry is updated.
    - `adv_hops` < stored hops: hops and Q-value are replaced.
    - `adv_hops` == stored hops: only the Q-value is replaced.
    - `adv_hops` > stored hops: the advertisement is ignored.
  - New ID with `count < ENTRIES`: written to slot `count`; `count` increments.
  - New ID with the table full: dropped; `overflow` is set to 1.
- `clear` in COLLECT zeroes all entries, `count` and `overflow`. It has priority over an advertisement accepted in the same cycle, which is discarded.
- `flush` in COLLECT moves the state to EMIT with index 0. An advertisement accepted in the same cycle is written first and is included in the emission.
- EMIT behaviour:
  - Each cycle, the entry at the current index is registered onto the outputs with `en_KCH = 1`, and the index increments.
  - When the index reaches `count`, the state moves to DONE.
- DONE: `emit_done = 1` and `en_KCH = 0`; the next state is COLLECT. The table is retained.
- `clear` during EMIT aborts emission: the table is cleared, the state returns to COLLECT, `en_KCH` is 0 on the next cycle, and no `emit_done` pulse is produced.
- `flush` during EMIT or DONE is ignored.
- Outputs hold their last value when `en_KCH = 0`. This is don't-care for consumers.

## Timing
- Reset values:
  - State COLLECT and `adv_ready = 1`.
  - `CH_ID`, `CH_QValue` and `CH_Hops` are 0.
  - `en_KCH`, `emit_done` and `overflow` are 0.
  - `count` is 0 and all table entries are 0.
- An advertisement accepted at edge N is reflected in `count` and the table after edge N.
- Flush latency:
  - `flush` sampled at edge N: entry k is valid after edge N+1+k.
  - `emit_done` is high after edge N+1+`count`.
- Flush with `count == 0`: `emit_done` is high after edge N+1; `en_KCH` never rises.
- `rst` asserted mid-emission: all state returns to reset values immediately, independent of the clock.

## Configuration
- `CH_DEDUP_EN` defined:
  - Duplicate-ID lookup and merge operate as described in Operation.
  - The lookup is a parallel compare across all entries.
- `CH_DEDUP_EN` undefined:
  - There is no lookup logic.
  - Every advertisement with a non-zero ID is appended while `count < ENTRIES`, or dropped with `overflow` set when the table is full.
  - Duplicate IDs may therefore occupy several slots.

## Test plan
- Reset, then three advertisements (ID 5, Q 0x6000, hops 2), (ID 7, Q 0x7333, hops 2), (ID 9, Q 0x4000, hops 3), then flush:
  - `count = 3`.
  - `en_KCH` is high for 3 cycles with IDs 5, 7, 9 in order.
  - `emit_done` pulses once, then `adv_ready = 1`.
- Dedup (`CH_DEDUP_EN` defined):
  - (ID 5, hops 3) then (ID 5, hops 2, Q 0x1000): one entry, hops 2, Q 0x1000.
  - A further (ID 5, hops 4): entry unchanged, `count = 1`.
- Overflow: 17 distinct non-zero IDs:
  - `count = 16` and `overflow = 1`.
  - Flush emits the first 16 IDs only.
  - `clear` sets `count = 0` and `overflow = 0`.
- Boundary cycles:
  - Flush with an empty table: `emit_done` high one cycle after flush, no `en_KCH`.
  - ID 0 advertisement: `count` unchanged.
- Simultaneous events:
  - `flush` and an advertisement (ID 3) in the same cycle: ID 3 is the last emitted entry.
  - `clear` and an advertisement in the same cycle: `count = 0`.
- Abort:
  - `clear` on the 2nd emission cycle of a 4-entry table: `en_KCH` low on the next cycle, no `emit_done`, `count = 0`.
  - Asynchronous `rst` mid-emission: all outputs go to 0 without waiting for a clock edge.
